// File: rtl/dispatch_unit_p.sv
// Dual-issue dispatch stage: allocates reservation stations per instruction class,
// renames sources through a register tag table and tracks RS occupancy from completions.
module dispatch_unit_p #(
  parameter int NUM_REGS = 4,
  parameter int ADD_RS   = 3,
  parameter int MUL_RS   = 2,
  parameter int LD_RS    = 2,
  parameter int ST_RS    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst0,
  input  logic [31:0] inst1,
  input  logic [1:0]  inst_valid,
  output logic [1:0]  stall,
  output logic [1:0]  issue_valid,
  output logic [39:0] issue_bus0,
  output logic [39:0] issue_bus1,
  output logic [1:0]  src_rdy0,
  output logic [1:0]  src_rdy1,
  input  logic [2:0]  cdb_valid,
  input  logic [23:0] cdb_tag,
  input  logic        st_done_valid,
  input  logic [7:0]  st_done_tag,
  input  logic        flush
);

  localparam int TOTAL_RS = ADD_RS + MUL_RS + LD_RS + ST_RS;
  localparam int MUL_BASE = ADD_RS + 1;
  localparam int LD_BASE  = MUL_BASE + MUL_RS;
  localparam int ST_BASE  = LD_BASE + LD_RS;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;

  localparam logic [2:0] CL_NOP = 3'd0;
  localparam logic [2:0] CL_ADD = 3'd1;
  localparam logic [2:0] CL_MUL = 3'd2;
  localparam logic [2:0] CL_LD  = 3'd3;
  localparam logic [2:0] CL_ST  = 3'd4;

  function automatic logic [2:0] decode(input logic [7:0] op);
    case (op)
      OP_LOAD:  return CL_LD;
      OP_STORE: return CL_ST;
      OP_ADD:   return CL_ADD;
      OP_MULTI: return CL_MUL;
      default:  return CL_NOP;
    endcase
  endfunction

  function automatic int cls_lo(input logic [2:0] c);
    case (c)
      CL_MUL:  return MUL_BASE;
      CL_LD:   return LD_BASE;
      CL_ST:   return ST_BASE;
      default: return 1;
    endcase
  endfunction

  // NOP yields an empty range (hi < lo), so it never finds a free entry.
  function automatic int cls_hi(input logic [2:0] c);
    case (c)
      CL_ADD:  return ADD_RS;
      CL_MUL:  return LD_BASE - 1;
      CL_LD:   return ST_BASE - 1;
      CL_ST:   return TOTAL_RS;
      default: return 0;
    endcase
  endfunction

  function automatic logic writes_dest(input logic [2:0] c);
    return (c == CL_ADD) || (c == CL_MUL) || (c == CL_LD);
  endfunction

  function automatic logic [7:0] find_free(input logic [TOTAL_RS:1] b, input int lo,
                                           input int hi, input logic [7:0] excl);
    logic [7:0] t;
    t = 8'd0;
    for (int i = hi; i >= lo; i--)
      if (!b[i] && (i[7:0] != excl)) t = i[7:0];
    return t;
  endfunction

  function automatic logic cdb_hit(input logic [7:0] t, input logic [2:0] cv, input logic [23:0] ct);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++)
      if (cv[k] && (ct[k*8 +: 8] == t)) hit = 1'b1;
    return hit;
  endfunction

  // {rdy, field}: a pending producer that completes on this edge reads as the register itself.
  function automatic logic [8:0] resolve(input logic [7:0] r, input logic [NUM_REGS*8-1:0] tbl,
                                         input logic [2:0] cv, input logic [23:0] ct);
    logic [7:0] t;
    t = 8'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (r == i[7:0]) t = tbl[i*8 +: 8];
    if (t == 8'd0 || cdb_hit(t, cv, ct)) return {1'b1, r};
    return {1'b0, t};
  endfunction

  // {src_rdy[1:0], issue_bus[39:0]}
  function automatic logic [41:0] build(input logic [2:0] c, input logic [7:0] tag,
                                        input logic [31:0] inst, input logic [8:0] s1,
                                        input logic [8:0] s2, input logic [8:0] sd);
    case (c)
      CL_ADD, CL_MUL: return {s2[8], s1[8], tag, inst[31:24], s1[7:0], s2[7:0], inst[23:16]};
      CL_LD:          return {2'b11, tag, inst[31:24], inst[15:0], inst[23:16]};
      CL_ST:          return {1'b1, sd[8], sd[7:0], inst[31:24], inst[15:0], tag};
      default:        return '0;
    endcase
  endfunction

  logic [TOTAL_RS:1]     busy_reg, busy_next;
  logic [NUM_REGS*8-1:0] tbl_flat;
  logic [1:0]            stall_reg, issue_valid_reg, src_rdy0_reg, src_rdy1_reg;
  logic [39:0]           issue_bus0_reg, issue_bus1_reg;

  logic [2:0]  cls0, cls1;
  logic [7:0]  tag0, tag1;
  logic        issue0, issue1, stall0, stall1, wr0, wr1;
  logic [8:0]  s1_0, s2_0, sd_0, s1_1, s2_1, sd_1;
  logic [41:0] out0, out1;

  always_comb begin
    cls0   = decode(inst0[31:24]);
    cls1   = decode(inst1[31:24]);
    wr0    = writes_dest(cls0);
    wr1    = writes_dest(cls1);
    tag0   = find_free(busy_reg, cls_lo(cls0), cls_hi(cls0), 8'd0);
    issue0 = inst_valid[0] && (cls0 != CL_NOP) && (tag0 != 8'd0);
    stall0 = inst_valid[0] && (cls0 != CL_NOP) && (tag0 == 8'd0);
    tag1   = find_free(busy_reg, cls_lo(cls1), cls_hi(cls1), issue0 ? tag0 : 8'd0);
    issue1 = inst_valid[1] && (cls1 != CL_NOP) && !stall0 && (tag1 != 8'd0);
    stall1 = stall0 || (inst_valid[1] && (cls1 != CL_NOP) && (tag1 == 8'd0));

    s1_0 = resolve(inst0[15:8], tbl_flat, cdb_valid, cdb_tag);
    s2_0 = resolve(inst0[7:0], tbl_flat, cdb_valid, cdb_tag);
    sd_0 = resolve(inst0[23:16], tbl_flat, cdb_valid, cdb_tag);
    // Younger slot sees the older slot's fresh tag before it reaches the table.
    s1_1 = (issue0 && wr0 && inst1[15:8] == inst0[23:16]) ? {1'b0, tag0}
         : resolve(inst1[15:8], tbl_flat, cdb_valid, cdb_tag);
    s2_1 = (issue0 && wr0 && inst1[7:0] == inst0[23:16]) ? {1'b0, tag0}
         : resolve(inst1[7:0], tbl_flat, cdb_valid, cdb_tag);
    sd_1 = (issue0 && wr0 && inst1[23:16] == inst0[23:16]) ? {1'b0, tag0}
         : resolve(inst1[23:16], tbl_flat, cdb_valid, cdb_tag);

    out0 = issue0 ? build(cls0, tag0, inst0, s1_0, s2_0, sd_0) : '0;
    out1 = issue1 ? build(cls1, tag1, inst1, s1_1, s2_1, sd_1) : '0;
  end

  always_comb begin
    busy_next = busy_reg;
    for (int i = 1; i <= TOTAL_RS; i++) begin
      if (cdb_hit(i[7:0], cdb_valid, cdb_tag) || (st_done_valid && st_done_tag == i[7:0]))
        busy_next[i] = 1'b0;
      if ((issue0 && tag0 == i[7:0]) || (issue1 && tag1 == i[7:0]))
        busy_next[i] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_tbl
      logic [7:0] tag_reg, tag_next;

      // Rename beats completion; slot 1 beats slot 0 on a shared dest.
      always_comb begin
        tag_next = tag_reg;
        if (tag_reg != 8'd0 && cdb_hit(tag_reg, cdb_valid, cdb_tag)) tag_next = 8'd0;
        if (issue0 && wr0 && inst0[23:16] == 8'(gi)) tag_next = tag0;
        if (issue1 && wr1 && inst1[23:16] == 8'(gi)) tag_next = tag1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     tag_reg <= 8'd0;
        else if (flush) tag_reg <= 8'd0;
        else            tag_reg <= tag_next;
      end

      assign tbl_flat[gi*8 +: 8] = tag_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      busy_reg        <= '0;
      stall_reg       <= 2'b00;
      issue_valid_reg <= 2'b00;
      issue_bus0_reg  <= '0;
      issue_bus1_reg  <= '0;
      src_rdy0_reg    <= 2'b00;
      src_rdy1_reg    <= 2'b00;
    end else begin
      busy_reg        <= busy_next;
      stall_reg       <= {stall1, stall0};
      issue_valid_reg <= {issue1, issue0};
      issue_bus0_reg  <= out0[39:0];
      issue_bus1_reg  <= out1[39:0];
      src_rdy0_reg    <= out0[41:40];
      src_rdy1_reg    <= out1[41:40];
    end
  end

  assign stall       = stall_reg;
  assign issue_valid = issue_valid_reg;
  assign issue_bus0  = issue_bus0_reg;
  assign issue_bus1  = issue_bus1_reg;
  assign src_rdy0    = src_rdy0_reg;
  assign src_rdy1    = src_rdy1_reg;

endmodule

// File: tb/tb_dispatch_unit_p.sv
// Scoreboard bench for dispatch_unit_p: each step pushes the expected registered
// outputs, then pops and compares them one edge later.
module tb_dispatch_unit_p;

  localparam logic [7:0] LD  = 8'h01;
  localparam logic [7:0] ST  = 8'h02;
  localparam logic [7:0] ADD = 8'h03;
  localparam logic [7:0] MUL = 8'h04;
  localparam logic [39:0] Z  = 40'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst0, inst1;
  logic [1:0]  inst_valid;
  logic [1:0]  stall, issue_valid, src_rdy0, src_rdy1;
  logic [39:0] issue_bus0, issue_bus1;
  logic [2:0]  cdb_valid;
  logic [23:0] cdb_tag;
  logic        st_done_valid;
  logic [7:0]  st_done_tag;
  logic        flush;

  always #5 clk = ~clk;

  dispatch_unit_p dut (
    .clk(clk), .rst_n(rst_n), .inst0(inst0), .inst1(inst1), .inst_valid(inst_valid),
    .stall(stall), .issue_valid(issue_valid), .issue_bus0(issue_bus0), .issue_bus1(issue_bus1),
    .src_rdy0(src_rdy0), .src_rdy1(src_rdy1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .st_done_valid(st_done_valid), .st_done_tag(st_done_tag), .flush(flush)
  );

  typedef struct packed {
    logic [1:0]  iv;
    logic [1:0]  st;
    logic [39:0] b0;
    logic [1:0]  r0;
    logic [39:0] b1;
    logic [1:0]  r1;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] a, input logic [7:0] b);
    return {op, d, a, b};
  endfunction

  function automatic logic [39:0] bus(input logic [7:0] t, input logic [7:0] op,
                                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    return {t, op, a, b, d};
  endfunction

  function automatic exp_t mk(input logic [1:0] iv, input logic [1:0] st, input logic [39:0] b0,
                              input logic [1:0] r0, input logic [39:0] b1, input logic [1:0] r1);
    exp_t e;
    e.iv = iv; e.st = st; e.b0 = b0; e.r0 = r0; e.b1 = b1; e.r1 = r1;
    return e;
  endfunction

  task automatic check_idle(input string name);
    check_eq({name, ".iv"},    40'(issue_valid), 40'd0);
    check_eq({name, ".stall"}, 40'(stall), 40'd0);
    check_eq({name, ".bus0"},  issue_bus0, Z);
    check_eq({name, ".bus1"},  issue_bus1, Z);
    check_eq({name, ".rdy0"},  40'(src_rdy0), 40'd0);
    check_eq({name, ".rdy1"},  40'(src_rdy1), 40'd0);
  endtask

  task automatic step(input string name, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] v, input logic [2:0] cv, input logic [23:0] ct,
                      input logic sv, input logic [7:0] stt, input logic fl, input exp_t e);
    exp_t x;
    inst0 = i0; inst1 = i1; inst_valid = v;
    cdb_valid = cv; cdb_tag = ct; st_done_valid = sv; st_done_tag = stt; flush = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_eq({name, ".iv"},    40'(issue_valid), 40'(x.iv));
    check_eq({name, ".stall"}, 40'(stall), 40'(x.st));
    check_eq({name, ".bus0"},  issue_bus0, x.b0);
    check_eq({name, ".bus1"},  issue_bus1, x.b1);
    check_eq({name, ".rdy0"},  40'(src_rdy0), 40'(x.r0));
    check_eq({name, ".rdy1"},  40'(src_rdy1), 40'(x.r1));
    $display("[TB] %s iv=%b stall=%b bus0=%h rdy0=%b bus1=%h rdy1=%b",
             name, issue_valid, stall, issue_bus0, src_rdy0, issue_bus1, src_rdy1);
    inst_valid = 2'b00; cdb_valid = 3'b000; st_done_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic go(input string name, input logic [31:0] i0, input logic [31:0] i1,
                    input logic [1:0] v, input exp_t e);
    step(name, i0, i1, v, 3'b000, 24'd0, 1'b0, 8'd0, 1'b0, e);
  endtask

  task automatic do_flush(input string name);
    step(name, ins(ADD, 1, 2, 3), ins(MUL, 2, 1, 0), 2'b11, 3'b000, 24'd0, 1'b0, 8'd0, 1'b1,
         mk(2'b00, 2'b00, Z, 2'b00, Z, 2'b00));
  endtask

  exp_t e_t1;

  initial begin
    rst_n = 1'b0; inst0 = '0; inst1 = '0; inst_valid = 2'b00;
    cdb_valid = 3'b000; cdb_tag = '0; st_done_valid = 1'b0; st_done_tag = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Pair rename with intra-pair forwarding, then read back the renamed registers.
    e_t1 = mk(2'b11, 2'b00, bus(1, ADD, 2, 3, 1), 2'b11, bus(4, MUL, 1, 0, 2), 2'b10);
    go("t1_pair", ins(ADD, 1, 2, 3), ins(MUL, 2, 1, 0), 2'b11, e_t1);
    go("t1_read", ins(ADD, 3, 1, 2), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(2, ADD, 1, 4, 3), 2'b00, Z, 2'b00));
    do_flush("t1_flush");

    // Exhaust the add stations, then free one via the CDB.
    go("t2_a", ins(ADD, 0, 1, 2), ins(ADD, 1, 2, 3), 2'b11,
       mk(2'b11, 2'b00, bus(1, ADD, 1, 2, 0), 2'b11, bus(2, ADD, 2, 3, 1), 2'b11));
    go("t2_b", ins(ADD, 0, 1, 2), ins(ADD, 1, 2, 3), 2'b11,
       mk(2'b01, 2'b10, bus(3, ADD, 2, 2, 0), 2'b10, Z, 2'b00));
    go("t2_c", ins(ADD, 0, 1, 2), ins(ADD, 1, 2, 3), 2'b11, mk(2'b00, 2'b11, Z, 2'b00, Z, 2'b00));
    go("t2_d", ins(ADD, 0, 1, 2), ins(ADD, 1, 2, 3), 2'b11, mk(2'b00, 2'b11, Z, 2'b00, Z, 2'b00));
    step("t2_cdb", ins(ADD, 0, 1, 2), ins(ADD, 1, 2, 3), 2'b11, 3'b001, 24'h000002, 1'b0, 8'd0,
         1'b0, mk(2'b00, 2'b11, Z, 2'b00, Z, 2'b00));
    go("t2_freed", ins(ADD, 0, 1, 2), ins(ADD, 1, 2, 3), 2'b11,
       mk(2'b01, 2'b10, bus(2, ADD, 1, 2, 0), 2'b11, Z, 2'b00));
    do_flush("t2_flush");

    // Load completes on the same edge a consumer issues.
    go("t3_load", ins(LD, 3, 8'hAB, 8'hCD), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(6, LD, 8'hAB, 8'hCD, 3), 2'b11, Z, 2'b00));
    step("t3_bypass", ins(ADD, 0, 3, 3), 32'd0, 2'b01, 3'b100, 24'h060000, 1'b0, 8'd0, 1'b0,
         mk(2'b01, 2'b00, bus(1, ADD, 3, 3, 0), 2'b11, Z, 2'b00));
    go("t3_after", ins(ADD, 2, 3, 0), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(2, ADD, 3, 1, 2), 2'b01, Z, 2'b00));
    do_flush("t3_flush");

    // Store stations: fill, stall, free via store completion.
    go("t4_pair", ins(ST, 1, 8'h12, 8'h34), ins(ST, 2, 8'h56, 8'h78), 2'b11,
       mk(2'b11, 2'b00, bus(1, ST, 8'h12, 8'h34, 8), 2'b11, bus(2, ST, 8'h56, 8'h78, 9), 2'b11));
    go("t4_full", ins(ST, 3, 8'h00, 8'h10), 32'd0, 2'b01, mk(2'b00, 2'b11, Z, 2'b00, Z, 2'b00));
    step("t4_done", ins(ST, 3, 8'h00, 8'h10), 32'd0, 2'b01, 3'b000, 24'd0, 1'b1, 8'd8, 1'b0,
         mk(2'b00, 2'b11, Z, 2'b00, Z, 2'b00));
    go("t4_reuse", ins(ST, 3, 8'h00, 8'h10), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(3, ST, 8'h00, 8'h10, 8), 2'b11, Z, 2'b00));
    go("t4_partial", ins(ADD, 2, 0, 0), ins(ST, 2, 8'h9A, 8'hBC), 2'b11,
       mk(2'b01, 2'b10, bus(1, ADD, 0, 0, 2), 2'b11, Z, 2'b00));
    step("t4_done9", ins(ST, 2, 8'h9A, 8'hBC), 32'd0, 2'b01, 3'b000, 24'd0, 1'b1, 8'd9, 1'b0,
         mk(2'b00, 2'b11, Z, 2'b00, Z, 2'b00));
    go("t4_pend", ins(ST, 2, 8'h9A, 8'hBC), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(1, ST, 8'h9A, 8'hBC, 9), 2'b10, Z, 2'b00));
    do_flush("t4_flush");

    // Rename wins over a completion clearing the same register.
    go("t5_a", ins(ADD, 1, 0, 0), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(1, ADD, 0, 0, 1), 2'b11, Z, 2'b00));
    step("t5_b", ins(ADD, 1, 2, 3), 32'd0, 2'b01, 3'b001, 24'h000001, 1'b0, 8'd0, 1'b0,
         mk(2'b01, 2'b00, bus(2, ADD, 2, 3, 1), 2'b11, Z, 2'b00));
    go("t5_c", ins(ADD, 0, 1, 1), 32'd0, 2'b01,
       mk(2'b01, 2'b00, bus(1, ADD, 2, 2, 0), 2'b00, Z, 2'b00));
    do_flush("t5_flush");

    // Flush and asynchronous reset while stations are busy.
    go("t6_pair", ins(ADD, 1, 2, 3), ins(MUL, 2, 1, 0), 2'b11, e_t1);
    do_flush("t6_flush");
    go("t6_again", ins(ADD, 1, 2, 3), ins(MUL, 2, 1, 0), 2'b11, e_t1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    go("t6_post", ins(ADD, 3, 1, 2), ins(ADD, 0, 1, 2), 2'b11,
       mk(2'b11, 2'b00, bus(1, ADD, 1, 2, 3), 2'b11, bus(2, ADD, 1, 2, 0), 2'b11));
    go("t6_nop", ins(8'h00, 1, 2, 3), ins(ADD, 1, 1, 1), 2'b11,
       mk(2'b10, 2'b00, Z, 2'b00, bus(3, ADD, 1, 1, 1), 2'b11));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
